mcy_mutsel_ctrl: RTL and testbench
==================================

Name: mcy_mutsel_ctrl

Overview:
- Sequences mutation-coverage runs of the mutated cv32e40p decoder.
- Owns the 8-bit mutation select driven into the mutated decoder. Applies a newly requested index only at an instruction boundary.
- Compares a packed signature of golden vs mutated decoder outputs on every retired decode, then reports per-run verdict (killed / survived) with counters.
- Sits in the MCY decoder bench, between the DPI/testbench sequencer and the golden+mutated decoder pair.

Parameters:
- SIG_W, 128, width of the packed decoder-output signature compared each decode
- MAX_INSNS, 4096, decode count after which an undetected mutant is declared survived
- CNT_W, 16, width of the instruction and mismatch counters (saturating)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  new mutation run requested
- req_idx_i  in  8  mutation index; 0 = unmutated
- req_ready_o  out  1  controller accepts a request (IDLE or DONE only)
- id_busy_i  in  1  an instruction is mid-decode (multicycle or stalled); mutsel must not change
- dec_valid_i  in  1  one decode is completing this cycle (deassert_we low, ID advancing)
- sig_golden_i  in  SIG_W  golden decoder output signature
- sig_mutant_i  in  SIG_W  mutated decoder output signature
- abort_i  in  1  testbench abort of current run
- mutsel_o  out  8  select to mutated decoder
- run_active_o  out  1  high in ARM and ACTIVE
- done_o  out  1  one-cycle pulse on entering DONE
- killed_o  out  1  verdict: at least one mismatch observed (valid while in DONE)
- first_mis_insn_o  out  CNT_W  decode number (0-based) of first mismatch
- insn_cnt_o  out  CNT_W  decodes checked in current/last run
- mis_cnt_o  out  CNT_W  total mismatching decodes in current/last run

Behaviour:
- Reset values: every output 0, except req_ready_o = 1. State = IDLE.
- States: IDLE, ARM, ACTIVE, DONE.
- IDLE/DONE -> ARM when req_valid_i && req_ready_o.
  - Latch req_idx_i into a pending register.
  - Clear insn_cnt_o, mis_cnt_o, first_mis_insn_o and killed_o in the same edge.
  - req_ready_o low from the next cycle.
- ARM: mutsel_o holds its previous value while id_busy_i = 1.
  - First cycle with id_busy_i = 0: mutsel_o <= pending, state -> ACTIVE.
  - Compare starts on the cycle after mutsel_o changes (one-cycle settle).
- ACTIVE: on each dec_valid_i, insn_cnt_o += 1 (saturating at all-ones).
  - On mismatch (sig_golden_i != sig_mutant_i), mis_cnt_o += 1 (saturating).
  - On the first mismatch, killed_o <= 1 and first_mis_insn_o <= pre-increment insn_cnt_o.
  - dec_valid_i low: no compare, no count.
- ACTIVE -> DONE when the registered insn_cnt reaches MAX_INSNS (checked after the update), or on the first mismatch.
  - Early exit on first kill is fixed behaviour.
  - done_o pulses for one cycle on entry to DONE.
  - mutsel_o returns to 0 on DONE entry.
- abort_i, in ARM or ACTIVE: -> DONE next cycle, killed_o unchanged, mutsel_o <= 0, done_o pulses. Ignored in IDLE/DONE.
- Simultaneous mismatch and count reaching MAX_INSNS: killed wins (killed_o = 1).
- Request during ARM/ACTIVE: not accepted (req_ready_o = 0); requester holds valid.
- DONE holds counters and verdict until the next accepted request. req_ready_o = 1 in DONE.
- Async reset mid-run: immediately back to IDLE, mutsel_o = 0, run discarded.

Decomposition:
- Package mcy_pkg holds:
  - typedef mcy_state_e {IDLE, ARM, ACTIVE, DONE}
  - constant MUTSEL_NONE = 8'd0
  - typedef mcy_verdict_t {killed, first_mis_insn, mis_cnt}
- One sub-module: mcy_sat_counter (CNT_W-wide saturating counter with clear and enable), instantiated twice.

Test Plan:
- Request idx 5 with id_busy_i = 0 and equal signatures, dec_valid_i every cycle, MAX_INSNS = 16 -> mutsel_o = 5 one cycle after accept; done_o after 16 decodes; killed_o = 0; insn_cnt_o = 16; mutsel_o back to 0.
- Request idx 9 while id_busy_i = 1 for 3 cycles -> mutsel_o stays 0 for those 3 cycles, then becomes 9; no decodes counted before the change.
- Signatures differ on the 7th decode (index 6) -> killed_o = 1, first_mis_insn_o = 6, mis_cnt_o = 1, done_o pulses the following cycle.
- abort_i asserted mid-ACTIVE after 3 decodes -> DONE next cycle, insn_cnt_o = 3, killed_o = 0, mutsel_o = 0.
- Mismatch on the same decode that reaches MAX_INSNS -> killed_o = 1.
- rst_n pulsed low mid-ACTIVE with mutsel_o = 12 -> outputs zero asynchronously, req_ready_o = 1; a new request for idx 3 then runs normally.

Source files
------------

// File: rtl/mcy_mutsel_ctrl_pkg.sv
// Shared types and constants for the MCY decoder mutation-select controller.
package mcy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ACTIVE,
    DONE
  } mcy_state_e;

  localparam logic [7:0] MUTSEL_NONE = 8'd0;
  localparam int         MCY_CNT_W   = 16;

  typedef struct packed {
    logic                 killed;
    logic [MCY_CNT_W-1:0] first_mis_insn;
    logic [MCY_CNT_W-1:0] mis_cnt;
  } mcy_verdict_t;

endpackage

// File: rtl/mcy_mutsel_ctrl_if.sv
// Sequencer/decoder-pair bundle for the mutation-select controller.
// The master side is the bench sequencer, the slave side is the controller.
interface mcy_mutsel_ctrl_if #(
  parameter int SIG_W = 128,
  parameter int CNT_W = 16
);

  logic             req_valid_i;
  logic [7:0]       req_idx_i;
  logic             req_ready_o;
  logic             id_busy_i;
  logic             dec_valid_i;
  logic [SIG_W-1:0] sig_golden_i;
  logic [SIG_W-1:0] sig_mutant_i;
  logic             abort_i;
  logic [7:0]       mutsel_o;
  logic             run_active_o;
  logic             done_o;
  logic             killed_o;
  logic [CNT_W-1:0] first_mis_insn_o;
  logic [CNT_W-1:0] insn_cnt_o;
  logic [CNT_W-1:0] mis_cnt_o;

  modport master (
    output req_valid_i, req_idx_i, id_busy_i, dec_valid_i,
           sig_golden_i, sig_mutant_i, abort_i,
    input  req_ready_o, mutsel_o, run_active_o, done_o, killed_o,
           first_mis_insn_o, insn_cnt_o, mis_cnt_o
  );

  modport slave (
    input  req_valid_i, req_idx_i, id_busy_i, dec_valid_i,
           sig_golden_i, sig_mutant_i, abort_i,
    output req_ready_o, mutsel_o, run_active_o, done_o, killed_o,
           first_mis_insn_o, insn_cnt_o, mis_cnt_o
  );

endinterface

// File: rtl/mcy_mutsel_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over count.
module mcy_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mcy_mutsel_ctrl.sv
// Mutation-run sequencer: applies the mutation select at an instruction boundary,
// compares golden vs mutant decode signatures and reports a killed/survived verdict.
module mcy_mutsel_ctrl #(
  parameter int SIG_W     = 128,
  parameter int MAX_INSNS = 4096,
  parameter int CNT_W     = 16
) (
  input logic              clk,
  input logic              rst_n,
  mcy_mutsel_ctrl_if.slave bus
);

  import mcy_pkg::*;

  localparam logic [CNT_W-1:0] LAST_INSN = CNT_W'(MAX_INSNS - 1);

  mcy_state_e       state;
  logic [7:0]       pending_idx;
  logic [SIG_W-1:0] sig_diff;
  logic             accept;
  logic             abort_run;
  logic             count_en;
  logic             mismatch;
  logic             hit_max;
  logic             finish_run;

  // Early exit on the first kill means any mismatch seen in ACTIVE is the first one.
  assign sig_diff   = bus.sig_golden_i ^ bus.sig_mutant_i;
  assign accept     = bus.req_valid_i && bus.req_ready_o;
  assign abort_run  = bus.abort_i && ((state == ARM) || (state == ACTIVE));
  assign count_en   = (state == ACTIVE) && bus.dec_valid_i && !bus.abort_i;
  assign mismatch   = count_en && (|sig_diff);
  assign hit_max    = count_en && (bus.insn_cnt_o == LAST_INSN);
  assign finish_run = abort_run || mismatch || hit_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      pending_idx          <= MUTSEL_NONE;
      bus.mutsel_o         <= MUTSEL_NONE;
      bus.req_ready_o      <= 1'b1;
      bus.run_active_o     <= 1'b0;
      bus.done_o           <= 1'b0;
      bus.killed_o         <= 1'b0;
      bus.first_mis_insn_o <= '0;
    end else begin
      bus.done_o <= 1'b0;
      if (accept) begin
        state                <= ARM;
        pending_idx          <= bus.req_idx_i;
        bus.req_ready_o      <= 1'b0;
        bus.run_active_o     <= 1'b1;
        bus.killed_o         <= 1'b0;
        bus.first_mis_insn_o <= '0;
      end else if (finish_run) begin
        state            <= DONE;
        bus.mutsel_o     <= MUTSEL_NONE;
        bus.req_ready_o  <= 1'b1;
        bus.run_active_o <= 1'b0;
        bus.done_o       <= 1'b1;
        if (mismatch) begin
          bus.killed_o         <= 1'b1;
          bus.first_mis_insn_o <= bus.insn_cnt_o;
        end
      end else if ((state == ARM) && !bus.id_busy_i) begin
        // Select only moves between instructions; compare starts the cycle after.
        state        <= ACTIVE;
        bus.mutsel_o <= pending_idx;
      end
    end
  end

  mcy_sat_counter #(.CNT_W(CNT_W)) u_insn_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (count_en),
    .cnt   (bus.insn_cnt_o)
  );

  mcy_sat_counter #(.CNT_W(CNT_W)) u_mis_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (mismatch),
    .cnt   (bus.mis_cnt_o)
  );

endmodule

// File: tb/tb_mcy_mutsel_ctrl.sv
// Scoreboard bench for mcy_mutsel_ctrl: directed runs from the test plan plus
// randomized runs, each checked against a per-decode behavioural run model.
module tb_mcy_mutsel_ctrl;

  import mcy_pkg::*;

  localparam int SIG_W     = 128;
  localparam int CNT_W     = 16;
  localparam int MAX_INSNS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mcy_mutsel_ctrl_if #(.SIG_W(SIG_W), .CNT_W(CNT_W)) bus ();

  mcy_mutsel_ctrl #(
    .SIG_W     (SIG_W),
    .MAX_INSNS (MAX_INSNS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    mcy_verdict_t     v;
    logic [CNT_W-1:0] insn_cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_done = 1'b0;

  // A run plan: what the sequencer does in each ACTIVE cycle.
  bit plan_dv[$];
  bit plan_mm[$];
  bit plan_ab[$];

  int m_cnt;
  int m_mis;
  int m_first;
  bit m_killed;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic report_fail(input string name, input string msg);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: %s", name, msg);
  endtask

  // Run model: decodes count until a mismatch kills the mutant, the decode
  // budget is used up, or the run is aborted.
  function automatic bit model_step(input bit dv, input bit mm, input bit ab);
    if (ab) return 1'b1;
    if (!dv) return 1'b0;
    if (mm) begin
      m_killed = 1'b1;
      m_first  = m_cnt;
      m_mis    = m_mis + 1;
      m_cnt    = m_cnt + 1;
      return 1'b1;
    end
    m_cnt = m_cnt + 1;
    return (m_cnt >= MAX_INSNS);
  endfunction

  function automatic void plan_clear();
    plan_dv.delete();
    plan_mm.delete();
    plan_ab.delete();
    m_cnt    = 0;
    m_mis    = 0;
    m_first  = 0;
    m_killed = 1'b0;
  endfunction

  function automatic bit plan_add(input bit dv, input bit mm, input bit ab);
    plan_dv.push_back(dv);
    plan_mm.push_back(mm);
    plan_ab.push_back(ab);
    return model_step(dv, mm, ab);
  endfunction

  task automatic plan_random();
    bit stop;
    bit ab;
    bit dv;
    bit mm;
    stop = 1'b0;
    plan_clear();
    while (!stop) begin
      ab   = ($urandom_range(0, 39) == 0);
      dv   = ab ? 1'b0 : ($urandom_range(0, 3) != 0);
      mm   = dv && ($urandom_range(0, 24) == 0);
      stop = plan_add(dv, mm, ab);
    end
  endtask

  task automatic drive_cycle(input bit dv, input bit mm);
    logic [SIG_W-1:0] g;
    g = {$urandom, $urandom, $urandom, $urandom};
    bus.dec_valid_i  = dv;
    bus.sig_golden_i = g;
    if (dv && !mm) bus.sig_mutant_i = g;
    else if (dv) bus.sig_mutant_i = g ^ (SIG_W'(1) << $urandom_range(0, SIG_W - 1));
    else bus.sig_mutant_i = ~g;
  endtask

  task automatic drive_idle();
    bus.req_valid_i = 1'b0;
    bus.id_busy_i   = 1'b0;
    bus.abort_i     = 1'b0;
    drive_cycle(1'b0, 1'b0);
  endtask

  task automatic wait_ready();
    int waited;
    waited = 0;
    while (bus.req_ready_o !== 1'b1 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (bus.req_ready_o !== 1'b1) report_fail("req_ready_timeout", "controller never offered ready");
  endtask

  // Issues one run following the current plan; the expected verdict goes to the scoreboard.
  task automatic applyStimulus(input logic [7:0] idx, input int busy);
    exp_t e;
    e.v.killed         = m_killed;
    e.v.first_mis_insn = MCY_CNT_W'(m_first);
    e.v.mis_cnt        = MCY_CNT_W'(m_mis);
    e.insn_cnt         = CNT_W'(m_cnt);
    wait_ready();
    exp_q.push_back(e);
    bus.req_valid_i = 1'b1;
    bus.req_idx_i   = idx;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    bus.req_idx_i   = 8'($urandom);
    checkOutput("req_ready_low", bus.req_ready_o, 0);
    checkOutput("run_active", bus.run_active_o, 1);
    for (int b = 0; b < busy; b++) begin
      bus.id_busy_i = 1'b1;
      drive_cycle(1'b1, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("mutsel_hold_busy", bus.mutsel_o, MUTSEL_NONE);
    end
    bus.id_busy_i = 1'b0;
    drive_cycle(1'b1, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("mutsel_applied", bus.mutsel_o, idx);
    foreach (plan_dv[k]) begin
      drive_cycle(plan_dv[k], plan_mm[k]);
      bus.abort_i = plan_ab[k];
      @(posedge clk);
      #1;
    end
    drive_idle();
    for (int w = 0; w < 6 && exp_q.size() != 0; w++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      report_fail("done_timeout", "no done_o pulse for the run");
      exp_q.delete();
    end
  endtask

  // Monitor: every done_o pulse retires one scoreboard entry.
  always @(negedge clk) begin
    if (bus.done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        report_fail("unexpected_done", "done_o with no run outstanding");
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("killed", bus.killed_o, mon_e.v.killed);
        checkOutput("first_mis_insn", bus.first_mis_insn_o, mon_e.v.first_mis_insn);
        checkOutput("mis_cnt", bus.mis_cnt_o, mon_e.v.mis_cnt);
        checkOutput("insn_cnt", bus.insn_cnt_o, mon_e.insn_cnt);
        checkOutput("mutsel_cleared", bus.mutsel_o, MUTSEL_NONE);
        checkOutput("req_ready_done", bus.req_ready_o, 1);
        checkOutput("run_active_done", bus.run_active_o, 0);
      end
      checkOutput("done_single_pulse", prev_done, 0);
    end
    prev_done = bus.done_o;
  end

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_mutsel"}, bus.mutsel_o, 0);
    checkOutput({tag, "_req_ready"}, bus.req_ready_o, 1);
    checkOutput({tag, "_run_active"}, bus.run_active_o, 0);
    checkOutput({tag, "_done"}, bus.done_o, 0);
    checkOutput({tag, "_killed"}, bus.killed_o, 0);
    checkOutput({tag, "_insn_cnt"}, bus.insn_cnt_o, 0);
    checkOutput({tag, "_mis_cnt"}, bus.mis_cnt_o, 0);
    checkOutput({tag, "_first_mis"}, bus.first_mis_insn_o, 0);
  endtask

  // Reset in the middle of an ACTIVE run with select 12.
  task automatic reset_mid_run();
    wait_ready();
    bus.req_valid_i = 1'b1;
    bus.req_idx_i   = 8'd12;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_run_mutsel", bus.mutsel_o, 12);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, 1'b0);
      @(posedge clk);
      #1;
    end
    checkOutput("rst_run_insn_cnt", bus.insn_cnt_o, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit stop;
    bus.req_idx_i = 8'd0;
    drive_idle();
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] clean run, idx 5");
    plan_clear();
    for (int k = 0; k < MAX_INSNS; k++) void'(plan_add(1'b1, 1'b0, 1'b0));
    applyStimulus(8'd5, 0);

    $display("[TB] busy for 3 cycles, mismatch on decode 6, idx 9");
    plan_clear();
    stop = 1'b0;
    for (int k = 0; !stop; k++) stop = plan_add(1'b1, k == 6, 1'b0);
    applyStimulus(8'd9, 3);

    $display("[TB] abort after 3 decodes");
    plan_clear();
    for (int k = 0; k < 3; k++) void'(plan_add(1'b1, 1'b0, 1'b0));
    void'(plan_add(1'b0, 1'b0, 1'b1));
    applyStimulus(8'd7, 1);

    $display("[TB] mismatch on the final budgeted decode");
    plan_clear();
    for (int k = 0; k < MAX_INSNS; k++) void'(plan_add(1'b1, k == MAX_INSNS - 1, 1'b0));
    applyStimulus(8'd200, 0);

    $display("[TB] reset mid-run, then idx 3");
    reset_mid_run();
    plan_clear();
    for (int k = 0; k < MAX_INSNS; k++) void'(plan_add(1'b1, 1'b0, 1'b0));
    applyStimulus(8'd3, 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 30; r++) begin
      plan_random();
      applyStimulus(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
